// File: rtl/corr_trigger_gen.sv
// corr_trigger_gen: threshold trigger on two correlation rings with OR/AND coincidence, holdoff and hit scalers (scalers built only with CORR_TRIG_SCALER_EN)
module corr_trigger_gen #(
  parameter int CORR_BITS   = 12,
  parameter int SCALER_BITS = 16
) (
  input  logic                   sysclk_i,
  input  logic                   rst_n_i,
  input  logic [CORR_BITS-1:0]   corr_r0_i,
  input  logic [CORR_BITS-1:0]   corr_r1_i,
  input  logic                   corr_valid_i,
  input  logic                   enable_i,
  input  logic                   mode_i,
  input  logic [CORR_BITS-1:0]   thresh_i,
  input  logic [3:0]             window_i,
  input  logic [7:0]             holdoff_i,
  input  logic                   scaler_clear_i,
  output logic                   trig_o,
  output logic [1:0]             trig_src_o,
  output logic [CORR_BITS-1:0]   trig_max_o,
  output logic [SCALER_BITS-1:0] scaler_r0_o,
  output logic [SCALER_BITS-1:0] scaler_r1_o,
  output logic                   busy_o
);
  localparam logic [1:0] IDLE = 2'd0, ARMED_R0 = 2'd1, ARMED_R1 = 2'd2, HOLDOFF = 2'd3;
  logic [1:0] state, state_n;
  logic [7:0] cnt, cnt_n, hold_q, hold_sel;
  logic [CORR_BITS-1:0] stored, stored_n, max_v;
  logic hit0, hit1, fire;
  logic [1:0] src;
  assign hit0 = corr_valid_i && (corr_r0_i >= thresh_i);
  assign hit1 = corr_valid_i && (corr_r1_i >= thresh_i);
  assign busy_o = state != IDLE;
  // next state, counter reload and trigger qualification; one shared counter serves window and holdoff
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    stored_n = stored;
    fire = 1'b0;
    src = 2'b00;
    max_v = '0;
    hold_sel = hold_q;
    if (!enable_i) state_n = IDLE;
    else case (state)
      IDLE: begin
        hold_sel = holdoff_i;
        if (!mode_i ? (hit0 || hit1) : (hit0 && hit1)) begin
          fire = 1'b1;
          src = {hit1, hit0};
          max_v = (hit0 && hit1) ? ((corr_r0_i > corr_r1_i) ? corr_r0_i : corr_r1_i) : (hit0 ? corr_r0_i : corr_r1_i);
        end else if (mode_i && (hit0 || hit1) && window_i != 4'd0) begin
          state_n = hit0 ? ARMED_R0 : ARMED_R1;
          stored_n = hit0 ? corr_r0_i : corr_r1_i;
          cnt_n = {4'd0, window_i};
        end
      end
      ARMED_R0: begin
        fire = hit1;
        src = hit1 ? 2'b11 : 2'b00;
        max_v = (stored > corr_r1_i) ? stored : corr_r1_i;
        state_n = (cnt == 8'd1) ? IDLE : state;
        cnt_n = cnt - 8'd1;
      end
      ARMED_R1: begin
        fire = hit0;
        src = hit0 ? 2'b11 : 2'b00;
        max_v = (stored > corr_r0_i) ? stored : corr_r0_i;
        state_n = (cnt == 8'd1) ? IDLE : state;
        cnt_n = cnt - 8'd1;
      end
      default: begin
        state_n = (cnt == 8'd1) ? IDLE : HOLDOFF;
        cnt_n = cnt - 8'd1;
      end
    endcase
    if (fire) begin
      state_n = (hold_sel == 8'd0) ? IDLE : HOLDOFF;
      cnt_n = hold_sel;
    end
  end
  // state registers and registered trigger outputs; source and max hold until the next trigger
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt <= '0;
      hold_q <= '0;
      stored <= '0;
      trig_o <= 1'b0;
      trig_src_o <= '0;
      trig_max_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      stored <= stored_n;
      trig_o <= fire;
      if (state == IDLE) hold_q <= holdoff_i;
      if (fire) begin
        trig_src_o <= src;
        trig_max_o <= max_v;
      end
    end
  end
`ifdef CORR_TRIG_SCALER_EN
  logic [SCALER_BITS-1:0] sc0, sc1;
  // saturating hit scalers, counting in every state; clear wins over a same-cycle hit
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sc0 <= '0;
      sc1 <= '0;
    end else if (scaler_clear_i) begin
      sc0 <= '0;
      sc1 <= '0;
    end else begin
      if (hit0 && !(&sc0)) sc0 <= sc0 + SCALER_BITS'(1);
      if (hit1 && !(&sc1)) sc1 <= sc1 + SCALER_BITS'(1);
    end
  end
  assign scaler_r0_o = sc0;
  assign scaler_r1_o = sc1;
`else
  logic unused_clear;
  assign unused_clear = scaler_clear_i;
  assign scaler_r0_o = '0;
  assign scaler_r1_o = '0;
`endif
endmodule

// File: tb/tb_corr_trigger_gen.sv
// tb_corr_trigger_gen: directed and randomized checks of corr_trigger_gen against a timestamp-based reference model
module tb_corr_trigger_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, valid, en, mode, clr;
  logic [11:0] r0, r1, thresh;
  logic [3:0] win;
  logic [7:0] ho;
  logic trig, busy;
  logic [1:0] src;
  logic [11:0] tmax;
  logic [15:0] s0, s1;
  int cmp = 0, fails = 0;
`ifdef CORR_TRIG_SCALER_EN
  localparam bit SC_ON = 1'b1;
`else
  localparam bit SC_ON = 1'b0;
`endif
  corr_trigger_gen dut (
    .sysclk_i(clk), .rst_n_i(rst_n), .corr_r0_i(r0), .corr_r1_i(r1), .corr_valid_i(valid),
    .enable_i(en), .mode_i(mode), .thresh_i(thresh), .window_i(win), .holdoff_i(ho),
    .scaler_clear_i(clr), .trig_o(trig), .trig_src_o(src), .trig_max_o(tmax),
    .scaler_r0_o(s0), .scaler_r1_o(s1), .busy_o(busy)
  );
  int n = 0, dead_until = 0, arm_last = 0, l_hold = 0;
  bit armed = 0, arm_r1 = 0;
  logic [11:0] arm_val;
  logic e_trig, e_busy;
  logic [1:0] e_src;
  logic [11:0] e_max;
  logic [15:0] e_s0, e_s1;
  function automatic logic [11:0] mx(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? a : b;
  endfunction
  task automatic model_reset;
    armed = 0; dead_until = 0; e_trig = 0; e_src = 0; e_max = 0; e_s0 = 0; e_s1 = 0; e_busy = 0;
  endtask
  task automatic fire(input logic [1:0] s, input logic [11:0] m);
    e_trig = 1; e_src = s; e_max = m; armed = 0; dead_until = n + 1 + l_hold;
  endtask
  task automatic model;
    bit h0, h1;
    h0 = valid && (r0 >= thresh);
    h1 = valid && (r1 >= thresh);
    e_trig = 0;
    if (!en) begin
      armed = 0; dead_until = 0;
    end else if (n < dead_until) begin
    end else if (armed) begin
      if (arm_r1 ? h0 : h1) fire(2'b11, mx(arm_val, arm_r1 ? r0 : r1));
      else if (n == arm_last) armed = 0;
    end else begin
      l_hold = ho;
      if (!mode && (h0 || h1)) fire({h1, h0}, (h0 && h1) ? mx(r0, r1) : (h0 ? r0 : r1));
      else if (mode && h0 && h1) fire(2'b11, mx(r0, r1));
      else if (mode && (h0 || h1) && win != 0) begin
        armed = 1; arm_r1 = !h0; arm_val = h0 ? r0 : r1; arm_last = n + int'(win);
      end
    end
    if (SC_ON) begin
      if (clr) begin e_s0 = 0; e_s1 = 0; end
      else begin
        if (h0 && e_s0 != 16'hFFFF) e_s0 = e_s0 + 1;
        if (h1 && e_s1 != 16'hFFFF) e_s1 = e_s1 + 1;
      end
    end
    e_busy = armed || (n + 1 < dead_until);
    n++;
  endtask
  task automatic tick;
    @(posedge clk);
    model();
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1; valid = 1; r0 = 12'hFFF; r1 = 12'hFFF; thresh = 0; en = 1; mode = 0; win = 0; ho = 0; clr = 0;
    #2 rst_n = 0;
    #1 cmp++;
    if ({trig, src, tmax, s0, s1, busy} !== '0) begin fails++; $display("FAIL reset_async: got %h want 0", {trig, src, tmax, s0, s1, busy}); end
    repeat (2) @(posedge clk);
    #1 cmp++;
    if ({trig, src, tmax, s0, s1, busy} !== '0) begin fails++; $display("FAIL reset_held: got %h want 0", {trig, src, tmax, s0, s1, busy}); end
    valid = 0; model_reset(); rst_n = 1;
  endtask
  task automatic test_or_mode;
    en = 1; mode = 0; thresh = 100; ho = 0; win = 0; clr = 0;
    r0 = 150; r1 = 20; valid = 1; tick();
    cmp++;
    if ({trig, src, tmax} !== {1'b1, 2'b01, 12'd150}) begin fails++; $display("FAIL or_r0: got %b/%b/%0d want 1/01/150", trig, src, tmax); end
    valid = 0; tick();
    cmp++;
    if ({trig, src, tmax} !== {1'b0, 2'b01, 12'd150}) begin fails++; $display("FAIL or_hold: got %b/%b/%0d want 0/01/150", trig, src, tmax); end
    r0 = 99; r1 = 100; valid = 1; tick();
    cmp++;
    if ({trig, src, tmax} !== {1'b1, 2'b10, 12'd100}) begin fails++; $display("FAIL or_r1_eq_thresh: got %b/%b/%0d want 1/10/100", trig, src, tmax); end
    r0 = 4000; r1 = 4000; valid = 0; tick();
    cmp++;
    if ({trig, src, tmax} !== {1'b0, 2'b10, 12'd100}) begin fails++; $display("FAIL or_invalid: got %b/%b/%0d want 0/10/100", trig, src, tmax); end
  endtask
  task automatic test_and_window;
    mode = 1; win = 3; ho = 0; thresh = 100;
    valid = 1; r0 = 200; r1 = 0; tick();
    cmp++;
    if ({trig, busy} !== 2'b01) begin fails++; $display("FAIL and_arm: got trig %b busy %b want 0 1", trig, busy); end
    valid = 0; tick();
    valid = 1; r0 = 0; r1 = 300; tick();
    cmp++;
    if ({trig, src, tmax, busy} !== {1'b1, 2'b11, 12'd300, 1'b0}) begin fails++; $display("FAIL and_c2: got %b/%b/%0d busy %b want 1/11/300 0", trig, src, tmax, busy); end
    r0 = 400; r1 = 0; tick();
    valid = 0; repeat (2) tick();
    valid = 1; r0 = 0; r1 = 300; tick();
    cmp++;
    if ({trig, src, tmax} !== {1'b1, 2'b11, 12'd400}) begin fails++; $display("FAIL and_last_cycle: got %b/%b/%0d want 1/11/400", trig, src, tmax); end
    r0 = 150; r1 = 160; tick();
    cmp++;
    if ({trig, src, tmax} !== {1'b1, 2'b11, 12'd160}) begin fails++; $display("FAIL and_both: got %b/%b/%0d want 1/11/160", trig, src, tmax); end
    r0 = 200; r1 = 0; tick();
    valid = 0; repeat (4) tick();
    cmp++;
    if ({trig, busy} !== 2'b00) begin fails++; $display("FAIL and_expire: got trig %b busy %b want 0 0", trig, busy); end
    valid = 1; r0 = 0; r1 = 300; tick();
    cmp++;
    if ({trig, src, tmax, busy} !== {1'b0, 2'b11, 12'd160, 1'b1}) begin fails++; $display("FAIL and_c5: got %b/%b/%0d busy %b want 0/11/160 1", trig, src, tmax, busy); end
    valid = 0; repeat (3) tick();
    win = 0; valid = 1; r0 = 500; r1 = 0; tick();
    cmp++;
    if ({trig, busy} !== 2'b00) begin fails++; $display("FAIL and_win0: got trig %b busy %b want 0 0", trig, busy); end
    valid = 0; tick();
  endtask
  task automatic test_holdoff;
    mode = 0; ho = 4; thresh = 100; r0 = 500; r1 = 0; valid = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      cmp++;
      if (trig !== (i % 5 == 0)) begin fails++; $display("FAIL holdoff4 cyc %0d: got %b want %b", i, trig, i % 5 == 0); end
    end
    valid = 0; repeat (5) tick();
    ho = 0; valid = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      cmp++;
      if (trig !== 1'b1) begin fails++; $display("FAIL holdoff0 cyc %0d: got %b want 1", i, trig); end
    end
    valid = 0; tick();
  endtask
  task automatic test_scaler;
    clr = 1; tick(); clr = 0;
    cmp++;
    if ({s0, s1} !== 32'd0) begin fails++; $display("FAIL sc_clear: got %h %h want 0 0", s0, s1); end
    mode = 0; ho = 0; thresh = 0; r0 = 1; r1 = 0; valid = 1;
    repeat (65535) tick();
    cmp++;
    if ({s0, s1} !== {2{16'hFFFF}}) begin fails++; $display("FAIL sc_full: got %h %h want ffff ffff", s0, s1); end
    tick();
    cmp++;
    if ({s0, s1} !== {2{16'hFFFF}}) begin fails++; $display("FAIL sc_sat: got %h %h want ffff ffff", s0, s1); end
    clr = 1; tick(); clr = 0;
    cmp++;
    if ({s0, s1} !== 32'd0) begin fails++; $display("FAIL sc_clr_hit: got %h %h want 0 0", s0, s1); end
    tick();
    cmp++;
    if ({s0, s1} !== {16'd1, 16'd1}) begin fails++; $display("FAIL sc_after_clr: got %h %h want 1 1", s0, s1); end
    valid = 0; tick();
  endtask
  task automatic test_ten_hits;
    clr = 1; valid = 0; tick(); clr = 0;
    mode = 0; ho = 0; thresh = 100; r0 = 200; r1 = 0; valid = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      cmp++;
      if ({trig, src, tmax} !== {1'b1, 2'b01, 12'd200}) begin fails++; $display("FAIL ten_trig %0d: got %b/%b/%0d want 1/01/200", i, trig, src, tmax); end
    end
    valid = 0; tick();
    cmp++;
    if ({s0, s1} !== {SC_ON ? 16'd10 : 16'd0, 16'd0}) begin fails++; $display("FAIL ten_scalers: got %0d %0d want %0d 0", s0, s1, SC_ON ? 10 : 0); end
  endtask
  task automatic test_reset_holdoff;
    mode = 0; ho = 10; thresh = 100; r0 = 300; r1 = 0; valid = 1; tick();
    cmp++;
    if (trig !== 1'b1) begin fails++; $display("FAIL rh_first: got %b want 1", trig); end
    valid = 0; repeat (2) tick();
    cmp++;
    if (busy !== 1'b1) begin fails++; $display("FAIL rh_busy: got %b want 1", busy); end
    #3 rst_n = 0;
    #1 cmp++;
    if ({trig, src, tmax, s0, s1, busy} !== '0) begin fails++; $display("FAIL rh_async: got %h want 0", {trig, src, tmax, s0, s1, busy}); end
    @(posedge clk);
    #1 model_reset(); rst_n = 1; ho = 0;
    tick();
    valid = 1; tick();
    cmp++;
    if ({trig, src, tmax, busy} !== {1'b1, 2'b01, 12'd300, 1'b0}) begin fails++; $display("FAIL rh_after: got %b/%b/%0d busy %b want 1/01/300 0", trig, src, tmax, busy); end
    valid = 0; tick();
  endtask
  task automatic test_random;
    for (int i = 0; i < 800; i++) begin
      valid = ($urandom % 4) != 0;
      r0 = 12'($urandom); r1 = 12'($urandom);
      thresh = 12'($urandom_range(1000, 3500));
      mode = $urandom % 3 != 0;
      win = 4'($urandom % 5);
      ho = 8'($urandom % 4);
      en = ($urandom % 16) != 0;
      clr = ($urandom % 32) == 0;
      tick();
      cmp++;
      if ({trig, src, tmax, s0, s1, busy} !== {e_trig, e_src, e_max, e_s0, e_s1, e_busy}) begin
        fails++;
        $display("FAIL random cyc %0d: got t%b s%b m%0d c%0d/%0d b%b want t%b s%b m%0d c%0d/%0d b%b", i,
                 trig, src, tmax, s0, s1, busy, e_trig, e_src, e_max, e_s0, e_s1, e_busy);
      end
    end
    en = 1; valid = 0; clr = 0;
  endtask
  initial begin
    model_reset();
    test_reset();
    test_or_mode();
    test_and_window();
    test_holdoff();
    if (SC_ON) test_scaler();
    test_ten_hits();
    test_reset_holdoff();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule

// File: doc/corr_trigger_gen.md
CORR_TRIGGER_GEN -- requirements
Module: corr_trigger_gen

Interface
REQ-001 SHALL have parameter CORR_BITS, default 12, width of each correlation input.
REQ-002 SHALL have parameter SCALER_BITS, default 16, width of each hit scaler.
REQ-003 SHALL have port sysclk_i, input, 1, sole clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port corr_r0_i, input, CORR_BITS, ring-0 correlation value from the correlator stage.
REQ-006 SHALL have port corr_r1_i, input, CORR_BITS, ring-1 correlation value.
REQ-007 SHALL have port corr_valid_i, input, 1, correlation values are valid this cycle.
REQ-008 SHALL have port enable_i, input, 1, trigger enable.
REQ-009 SHALL have port mode_i, input, 1, coincidence mode: 0 = OR, 1 = AND.
REQ-010 SHALL have port thresh_i, input, CORR_BITS, unsigned hit threshold.
REQ-011 SHALL have port window_i, input, 4, AND-mode coincidence window in cycles.
REQ-012 SHALL have port holdoff_i, input, 8, post-trigger dead time in cycles.
REQ-013 SHALL have port scaler_clear_i, input, 1, synchronous scaler clear.
REQ-014 SHALL have port trig_o, output, 1, one-cycle trigger pulse.
REQ-015 SHALL have port trig_src_o, output, 2, {r1,r0} rings that contributed to the trigger.
REQ-016 SHALL have port trig_max_o, output, CORR_BITS, largest contributing correlation value.
REQ-017 SHALL have port scaler_r0_o, output, SCALER_BITS, ring-0 hit count.
REQ-018 SHALL have port scaler_r1_o, output, SCALER_BITS, ring-1 hit count.
REQ-019 SHALL have port busy_o, output, 1, high when state is not IDLE.

Function
REQ-020 SHALL compute hit_rX = corr_valid_i AND (corr_rX_i >= thresh_i), using an unsigned compare.
REQ-021 SHALL implement the states IDLE, ARMED_R0, ARMED_R1 and HOLDOFF.
REQ-022 SHALL sample mode_i, window_i and holdoff_i only in IDLE; these values hold for the rest of the sequence.
REQ-023 SHALL fire a trigger in IDLE under OR mode on any hit, with trig_src_o = {hit_r1,hit_r0} and trig_max_o = max of the hitting values.
REQ-024 SHALL fire a trigger in IDLE under AND mode only when both rings hit, with trig_src_o = 2'b11.
REQ-025 SHALL, in AND mode with a single hit and window_i != 0, go to ARMED_Rx, store that value, and load a counter with window_i.
REQ-026 SHALL, in ARMED_R0 (ARMED_R1 symmetric), fire a trigger on hit_r1 with trig_src_o = 2'b11 and trig_max_o = max(stored value, corr_r1_i).
REQ-027 SHALL, in ARMED_Rx without a hit, decrement the counter and return to IDLE with no trigger when the counter reaches 0.
REQ-028 SHALL make trig_o, trig_src_o and trig_max_o registered, asserted exactly 1 cycle after the qualifying input cycle, and held until the next trigger (except trig_o, which is a single-cycle pulse).
REQ-029 SHALL enter HOLDOFF after a trigger, lasting exactly holdoff_i cycles; if holdoff_i = 0, SHALL return directly to IDLE with triggering allowed on the next cycle.
REQ-030 SHALL ignore hits for triggering while in HOLDOFF.
REQ-031 SHALL, when enable_i = 0, force IDLE on the next edge and suppress trig_o; scalers keep counting.
REQ-032 SHALL increment scaler_rX once per cycle with hit_rX, in every state, saturating at all-ones.
REQ-033 SHALL give scaler_clear_i priority over a hit in the same cycle, so the scaler reads 0 afterwards.

Reset
REQ-034 SHALL, on rst_n_i low, immediately set state to IDLE and all counters, trig_o, trig_src_o, trig_max_o, scalers and busy_o to 0.
REQ-035 SHALL, on reset mid-ARMED or mid-HOLDOFF, emit no trigger, and the first trigger after release SHALL be able to fire from a fresh IDLE.

Configuration
REQ-036 SHALL compile the scalers in when CORR_TRIG_SCALER_EN is defined; when it is not defined, scaler_r0_o and scaler_r1_o SHALL be constant 0, no scaler flops SHALL exist, and scaler_clear_i SHALL be ignored.

Verification
REQ-037 SHALL cover: OR mode, thresh 100, r0=150 and r1=20 valid for one cycle -> trig_o pulse 1 cycle later, src 2'b01, max 150.
REQ-038 SHALL cover: AND mode, window 3, r0 hit at cycle 0 then r1=300 hit at cycle 2 -> trigger, src 2'b11, max = max(r0,300); same stimulus with r1 at cycle 5 -> no trigger.
REQ-039 SHALL cover: holdoff 4, continuous hits -> triggers exactly 5 cycles apart; holdoff 0 -> a trigger every cycle.
REQ-040 SHALL cover: a scaler driven to 0xFFFF that receives a further hit -> stays 0xFFFF; clear and hit in the same cycle -> 0.
REQ-041 SHALL cover: rst_n_i asserted during HOLDOFF -> all outputs 0 asynchronously, and a hit 1 cycle after release -> trigger.
REQ-042 SHALL cover: build without CORR_TRIG_SCALER_EN and 10 hits -> scalers read 0 and triggering is unchanged.
